// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the conv2d frame scheduler.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    DRAIN,
    WAIT,
    RESP
  } state_t;

  localparam int PIX_W = 8;
  localparam int RES_W = 16;

  function automatic int npix(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/conv_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps to
// index 0; it returns a one-hot grant and the winner's index.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    // NOTE: every output gets a default before the search so that no path leaves one unassigned (no latch).
    grant = '0;
    idx   = '0;
    found = 1'b0;
    // Pass one covers ptr..N-1, pass two covers the indices that wrap below ptr.
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (IDX_W'(i) >= ptr)) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (IDX_W'(i) < ptr)) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/conv_sched.sv
// Shares one streaming conv2d engine among NUM_REQ requesters: round-robin grant,
// frame fetch, stream, wait with timeout, tagged response. Optional macro: CONV_SCHED_PERF_EN.
module conv_sched
  import conv_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IMG_W   = 5,
  parameter int IMG_H   = 5,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 50
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_base,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         mem_rd_en,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [PIX_W-1:0]             mem_rd_data,
  output logic                         conv_start,
  output logic [PIX_W-1:0]             conv_in_data,
  input  logic                         conv_done,
  input  logic [RES_W-1:0]             conv_out_data,
  output logic                         resp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   resp_id,
  output logic [RES_W-1:0]             resp_data,
  output logic                         resp_err,
  output logic                         busy
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [15:0]                  perf_cycles,
  output logic [15:0]                  perf_jobs
`endif
);

  localparam int NPIX      = npix(IMG_W, IMG_H);
  localparam int CNT_W     = $clog2(NPIX) + 1;
  localparam int WCNT_W    = $clog2(TIMEOUT) + 1;
  localparam int IDX_W     = $clog2(NUM_REQ);
  localparam int DRAIN_LEN = 2;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [CNT_W-1:0]   pix_cnt;
  logic [WCNT_W-1:0]  wait_cnt;
  logic               rd_vld;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [ADDR_W-1:0]  base_sel;
  logic [IDX_W-1:0]   next_ptr;
  logic               wait_timeout;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .found (arb_any)
  );

  always_comb begin
    base_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) base_sel = req_base[i*ADDR_W +: ADDR_W];
    end
  end

  assign next_ptr     = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
  assign wait_timeout = (wait_cnt == WCNT_W'(TIMEOUT - 1));
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      pix_cnt      <= '0;
      wait_cnt     <= '0;
      rd_vld       <= 1'b0;
      grant        <= '0;
      mem_rd_en    <= 1'b0;
      mem_addr     <= '0;
      conv_start   <= 1'b0;
      conv_in_data <= '0;
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      resp_data    <= '0;
      resp_err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let this pipeline shift by one stage per clock, regardless of statement order.
      // Read issued -> data returns next cycle -> registered onto the engine port.
      rd_vld     <= mem_rd_en;
      conv_start <= rd_vld;
      if (rd_vld) conv_in_data <= mem_rd_data;
      resp_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (arb_any) begin
            grant     <= arb_grant;
            owner     <= arb_idx;
            rr_ptr    <= next_ptr;
            mem_addr  <= base_sel;
            mem_rd_en <= 1'b1;
            pix_cnt   <= '0;
            state     <= FEED;
          end
        end
        FEED: begin
          if (pix_cnt == CNT_W'(NPIX - 1)) begin
            mem_rd_en <= 1'b0;
            pix_cnt   <= '0;
            state     <= DRAIN;
          end else begin
            pix_cnt  <= pix_cnt + CNT_W'(1);
            mem_addr <= mem_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (pix_cnt == CNT_W'(DRAIN_LEN - 1)) begin
            wait_cnt <= '0;
            state    <= WAIT;
          end else begin
            pix_cnt <= pix_cnt + CNT_W'(1);
          end
        end
        WAIT: begin
          // Done wins over a timeout in the same cycle.
          if (conv_done) begin
            resp_valid <= 1'b1;
            resp_id    <= owner;
            resp_data  <= conv_out_data;
            resp_err   <= 1'b0;
            state      <= RESP;
          end else if (wait_timeout) begin
            resp_valid <= 1'b1;
            resp_id    <= owner;
            resp_data  <= '0;
            resp_err   <= 1'b1;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        RESP: begin
          grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONV_SCHED_PERF_EN
  logic [15:0] perf_cnt;

  // perf_cnt holds the number of cycles since the grant, with the current cycle included.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_cnt    <= '0;
      perf_cycles <= '0;
      perf_jobs   <= '0;
    end else begin
      if (state == IDLE && arb_any) begin
        perf_cnt <= 16'd1;
      end else if (state != IDLE && perf_cnt != 16'hFFFF) begin
        perf_cnt <= perf_cnt + 16'd1;
      end
      if (state == WAIT && (conv_done || wait_timeout)) begin
        perf_cycles <= (perf_cnt == 16'hFFFF) ? 16'hFFFF : perf_cnt + 16'd1;
        perf_jobs   <= perf_jobs + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_conv_sched.sv
// Scoreboard bench for conv_sched: memory and centre-3x3-sum engine models,
// expected responses queued at stimulus time and popped by a response monitor.
module tb_conv_sched;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 50;
  localparam int NPIX    = 25;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = '0;
  logic [15:0] req_base = '0;
  logic [1:0]  grant;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rd_data;
  logic        conv_start;
  logic [7:0]  conv_in_data;
  logic        conv_done;
  logic [15:0] conv_out_data;
  logic        resp_valid;
  logic [0:0]  resp_id;
  logic [15:0] resp_data;
  logic        resp_err;
  logic        busy;
`ifdef CONV_SCHED_PERF_EN
  logic [15:0] perf_cycles;
  logic [15:0] perf_jobs;
`endif

  always #5 clk = ~clk;

  conv_sched #(
    .NUM_REQ (NUM_REQ),
    .IMG_W   (5),
    .IMG_H   (5),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_base      (req_base),
    .grant         (grant),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_rd_data   (mem_rd_data),
    .conv_start    (conv_start),
    .conv_in_data  (conv_in_data),
    .conv_done     (conv_done),
    .conv_out_data (conv_out_data),
    .resp_valid    (resp_valid),
    .resp_id       (resp_id),
    .resp_data     (resp_data),
    .resp_err      (resp_err),
    .busy          (busy)
`ifdef CONV_SCHED_PERF_EN
    ,
    .perf_cycles   (perf_cycles),
    .perf_jobs     (perf_jobs)
`endif
  );

  // ---------------- memory and engine models ----------------
  logic [7:0] mem [256];
  logic [7:0] rd_q = '0;
  assign mem_rd_data = rd_q;
  always @(posedge clk) if (mem_rd_en) rd_q <= mem[mem_addr];

  logic        engine_en = 1'b1;
  logic        spur = 1'b0;
  int          eng_cnt = 0;
  logic [15:0] eng_sum = '0;
  logic [15:0] eng_res = '0;
  logic        d1 = 1'b0, d2 = 1'b0, eng_done = 1'b0;

  function automatic bit centre(input int p);
    return (p / 5 >= 1) && (p / 5 <= 3) && (p % 5 >= 1) && (p % 5 <= 3);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      eng_cnt <= 0; eng_sum <= '0; d1 <= 1'b0; d2 <= 1'b0; eng_done <= 1'b0;
    end else begin
      d1       <= 1'b0;
      d2       <= d1;
      eng_done <= d2 && engine_en;
      if (conv_start) begin
        if (eng_cnt == NPIX - 1) begin
          eng_res <= eng_sum + (centre(eng_cnt) ? 16'(conv_in_data) : 16'd0);
          eng_sum <= '0;
          eng_cnt <= 0;
          d1      <= 1'b1;
        end else begin
          eng_sum <= eng_sum + (centre(eng_cnt) ? 16'(conv_in_data) : 16'd0);
          eng_cnt <= eng_cnt + 1;
        end
      end
    end
  end

  assign conv_done     = eng_done | spur;
  assign conv_out_data = eng_done ? eng_res : 16'hDEAD;

  // ---------------- scoreboard and monitors ----------------
  typedef struct packed {
    logic [0:0]  id;
    logic [15:0] data;
    logic        err;
  } resp_t;

  resp_t      exp_q[$];
  resp_t      got;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         resp_seen = 0;
  int         last_start_cyc = 0;
  int         resp_cyc = 0;
  int         cur_run = 0, max_run = 0, runs = 0;
  logic [7:0] pix_q[$];
  logic [7:0] addr_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (conv_start) begin
      pix_q.push_back(conv_in_data);
      last_start_cyc = cyc;
      if (cur_run == 0) runs++;
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
    end else begin
      cur_run = 0;
    end
    if (mem_rd_en) addr_q.push_back(mem_addr);
    if (resp_valid) begin
      resp_cyc = cyc;
      resp_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 64'(resp_valid), 64'd0);
      end else begin
        got = exp_q.pop_front();
        check("resp_id", 64'(resp_id), 64'(got.id));
        check("resp_data", 64'(resp_data), 64'(got.data));
        check("resp_err", 64'(resp_err), 64'(got.err));
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [63:0] all_outs();
    return 64'({grant, mem_rd_en, mem_addr, conv_start, conv_in_data,
                resp_valid, resp_id, resp_data, resp_err, busy});
  endfunction

  task automatic init_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < NPIX; i++) begin
      mem[i]      = 8'(i + 1);
      mem[64 + i] = 8'(2 * (i + 1));
    end
  endtask

  task automatic start_test();
    rst = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    exp_q.delete();
    pix_q.delete();
    addr_q.delete();
    resp_seen = 0;
    runs = 0;
    max_run = 0;
    cur_run = 0;
    init_mem();
    req_base = {8'd64, 8'd0};
    rst = 1'b1;
  endtask

  task automatic wait_resps(input string name, input int target, input int budget);
    int n = 0;
    while (resp_seen < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, 64'(resp_seen), 64'(target));
  endtask

  task automatic wait_read_addr(input string name, input logic [7:0] addr);
    int n = 0;
    bit hit = 0;
    while (!hit && n < 60) begin
      @(negedge clk);
      n++;
      if (mem_rd_en && mem_addr == addr) hit = 1;
    end
    check(name, 64'(hit), 64'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int bad;

    // Single job: frame 1..25, centre sum 117.
    start_test();
    exp_q.push_back('{id: 1'b0, data: 16'd117, err: 1'b0});
    req = 2'b01;
    repeat (2) @(negedge clk);
    check("grant_single", 64'(grant), 64'h1);
    check("busy_single", 64'(busy), 64'd1);
    wait_resps("single_resp_count", 1, 200);
    req = 2'b00;
    check("single_pix_count", 64'(pix_q.size()), 64'(NPIX));
    bad = 0;
    foreach (pix_q[i]) if (pix_q[i] != 8'(i + 1)) bad++;
    check("single_pix_seq_bad", 64'(bad), 64'd0);
    check("single_start_run", 64'(max_run), 64'(NPIX));
    check("single_start_runs", 64'(runs), 64'd1);
    repeat (2) @(negedge clk);
    check("single_idle_after", 64'({busy, grant}), 64'd0);

    // Contention: id0 then id1, then id0 again by round robin.
    start_test();
    exp_q.push_back('{id: 1'b0, data: 16'd117, err: 1'b0});
    exp_q.push_back('{id: 1'b1, data: 16'd234, err: 1'b0});
    exp_q.push_back('{id: 1'b0, data: 16'd117, err: 1'b0});
    req = 2'b11;
    wait_resps("contention_resp_count", 3, 400);
    req = 2'b00;
    check("contention_queue_empty", 64'(exp_q.size()), 64'd0);

    // Timeout: engine silent.
    start_test();
    engine_en = 1'b0;
    exp_q.push_back('{id: 1'b0, data: 16'd0, err: 1'b1});
    req = 2'b01;
    wait_resps("timeout_resp_count", 1, 300);
    req = 2'b00;
    check("timeout_latency", 64'(resp_cyc - last_start_cyc), 64'(TIMEOUT + 1));
    repeat (2) @(negedge clk);
    check("timeout_idle_after", 64'({busy, grant}), 64'd0);
    engine_en = 1'b1;

    // Address wrap from F0.
    start_test();
    for (int i = 0; i < NPIX; i++) mem[(240 + i) % 256] = 8'(i + 1);
    req_base = {8'd64, 8'hF0};
    exp_q.push_back('{id: 1'b0, data: 16'd117, err: 1'b0});
    req = 2'b01;
    wait_resps("wrap_resp_count", 1, 200);
    req = 2'b00;
    check("wrap_addr_count", 64'(addr_q.size()), 64'(NPIX));
    bad = 0;
    foreach (addr_q[i]) if (addr_q[i] != 8'((240 + i) % 256)) bad++;
    check("wrap_addr_seq_bad", 64'(bad), 64'd0);

    // Reset mid-FEED at pixel 10: no response, then requester 1 wins.
    start_test();
    req = 2'b01;
    wait_read_addr("reach_pixel10", 8'd10);
    rst = 1'b0;
    req = 2'b10;
    @(negedge clk);
    check("midreset_outputs", all_outs(), 64'd0);
    exp_q.push_back('{id: 1'b1, data: 16'd234, err: 1'b0});
    rst = 1'b1;
    wait_resps("midreset_resp_count", 1, 200);
    req = 2'b00;
    check("midreset_queue_empty", 64'(exp_q.size()), 64'd0);

    // Spurious done during FEED is ignored.
    start_test();
    exp_q.push_back('{id: 1'b0, data: 16'd117, err: 1'b0});
    req = 2'b01;
    wait_read_addr("reach_pixel5", 8'd5);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    check("spurious_no_resp", 64'(resp_valid), 64'd0);
    wait_resps("spurious_resp_count", 1, 200);
    req = 2'b00;
    repeat (3) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
